// File: rtl/hwpe_ctrl_router_pkg.sv
// Shared constants, FSM state type and local-window decode for hwpe_ctrl_router.
// HWPE_CTRL_PERF_EN adds PERF_OFFS to the local window.
package hwpe_ctrl_router_pkg;

  localparam logic [7:0] CLK_EN_OFFS     = 8'h9C;
  localparam logic [7:0] MUX_SEL_OFFS    = 8'h98;
  localparam logic [7:0] EVT_CLR_OFFS    = 8'h94;
  localparam logic [7:0] EVT_STATUS_OFFS = 8'h90;
  localparam logic [7:0] BUSY_OFFS       = 8'h8C;
  localparam logic [7:0] PERF_OFFS       = 8'h88;

  typedef enum logic [1:0] {
    IDLE,
    LOCAL_RSP,
    WAIT_HWPE
  } state_e;

  function automatic logic is_local(input logic [7:0] offs);
    logic hit;
    hit = (offs == CLK_EN_OFFS) || (offs == MUX_SEL_OFFS) || (offs == EVT_CLR_OFFS) ||
          (offs == EVT_STATUS_OFFS) || (offs == BUSY_OFFS);
`ifdef HWPE_CTRL_PERF_EN
    hit = hit || (offs == PERF_OFFS);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_evt_sticky.sv
// Per-core sticky event flags: set by raw events, cleared by a write-1 mask,
// with set taking priority when both hit the same bit in one cycle.
module hwpe_ctrl_evt_sticky #(
  parameter int unsigned NrCores = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrCores-1:0] set_i,
  input  logic [NrCores-1:0] clr_i,
  output logic [NrCores-1:0] evt_o
);

  logic [NrCores-1:0] evt_q, evt_d;

  assign evt_d = (evt_q & ~clr_i) | set_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/hwpe_ctrl_router.sv
// Control-plane router: decodes peripheral requests to local housekeeping registers
// or to one HWPE. Optional busy-cycle counter at 0x88 enabled by HWPE_CTRL_PERF_EN.
module hwpe_ctrl_router
  import hwpe_ctrl_router_pkg::*;
#(
  parameter int unsigned NrHwpes   = 2,
  parameter int unsigned NrCores   = 8,
  parameter int unsigned IdWidth   = 8,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned SelLsb    = 8,
  parameter int unsigned SelWidth  = (NrHwpes > 1) ? $clog2(NrHwpes) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ctrl_q_valid_i,
  output logic                         ctrl_q_ready_o,
  input  logic [31:0]                  ctrl_q_addr_i,
  input  logic                         ctrl_q_write_i,
  input  logic [DataWidth-1:0]         ctrl_q_data_i,
  input  logic [DataWidth/8-1:0]       ctrl_q_strb_i,
  input  logic [IdWidth-1:0]           ctrl_q_user_i,
  output logic                         ctrl_p_valid_o,
  output logic [DataWidth-1:0]         ctrl_p_data_o,
  output logic [NrHwpes-1:0]           periph_req_o,
  input  logic [NrHwpes-1:0]           periph_gnt_i,
  output logic [31:0]                  periph_add_o,
  output logic                         periph_wen_o,
  output logic [DataWidth/8-1:0]       periph_be_o,
  output logic [DataWidth-1:0]         periph_data_o,
  output logic [IdWidth-1:0]           periph_id_o,
  input  logic [NrHwpes-1:0]           periph_r_valid_i,
  input  logic [NrHwpes*DataWidth-1:0] periph_r_data_i,
  input  logic [NrHwpes*NrCores-1:0]   hwpe_evt_i,
  input  logic [NrHwpes-1:0]           hwpe_busy_i,
  output logic [NrHwpes-1:0]           clk_en_o,
  output logic [SelWidth-1:0]          mux_sel_o,
  output logic [NrCores-1:0]           hwpe_evt_o
);

  state_e               state_q, state_d;
  logic [NrHwpes-1:0]   clk_en_q, clk_en_d;
  logic [SelWidth-1:0]  mux_sel_q, mux_sel_d, sel_q, sel_d, sel;
  logic [DataWidth-1:0] rdata_q, rdata_d, local_rdata;
  logic [7:0]           offs;
  logic                 sel_valid, local_acc, local_hs, hwpe_hs, wr_local;
  logic [NrCores-1:0]   evt_set, evt_clr;
  logic                 unused_addr;

  assign offs        = ctrl_q_addr_i[7:0];
  assign sel         = ctrl_q_addr_i[SelLsb +: SelWidth];
  assign sel_valid   = 32'(sel) < NrHwpes;
  assign unused_addr = ^ctrl_q_addr_i;

  // Anything we cannot forward safely (local, bad select, gated) completes locally.
  assign local_acc = is_local(offs) || !sel_valid || !clk_en_q[sel];
  assign wr_local  = local_hs && ctrl_q_write_i && is_local(offs);

  assign periph_add_o  = {24'h0, offs};
  assign periph_wen_o  = ~ctrl_q_write_i;
  assign periph_be_o   = ctrl_q_strb_i;
  assign periph_data_o = ctrl_q_data_i;
  assign periph_id_o   = ctrl_q_user_i;

`ifdef HWPE_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (hwpe_busy_i[mux_sel_q] && (perf_q != '1)) perf_d = perf_q + 32'd1;
    if (wr_local && (offs == PERF_OFFS)) perf_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) perf_q <= '0;
    else       perf_q <= perf_d;
  end
`endif

  always_comb begin
    local_rdata = '0;
    case (offs)
      CLK_EN_OFFS:     local_rdata = DataWidth'(clk_en_q);
      MUX_SEL_OFFS:    local_rdata = DataWidth'(mux_sel_q);
      EVT_STATUS_OFFS: local_rdata = DataWidth'(hwpe_evt_o);
      BUSY_OFFS:       local_rdata = DataWidth'(hwpe_busy_i);
`ifdef HWPE_CTRL_PERF_EN
      PERF_OFFS:       local_rdata = DataWidth'(perf_q);
`endif
      default:         local_rdata = '0;
    endcase
  end

  always_comb begin
    clk_en_d  = clk_en_q;
    mux_sel_d = mux_sel_q;
    evt_clr   = '0;
    if (wr_local) begin
      case (offs)
        CLK_EN_OFFS:  clk_en_d = ctrl_q_data_i[NrHwpes-1:0];
        MUX_SEL_OFFS: if (ctrl_q_data_i < DataWidth'(NrHwpes)) mux_sel_d = ctrl_q_data_i[SelWidth-1:0];
        EVT_CLR_OFFS: evt_clr = ctrl_q_data_i[NrCores-1:0];
        default:      ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    rdata_d        = rdata_q;
    ctrl_q_ready_o = 1'b0;
    ctrl_p_valid_o = 1'b0;
    ctrl_p_data_o  = '0;
    periph_req_o   = '0;
    local_hs       = 1'b0;
    hwpe_hs        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_q_valid_i) begin
          if (local_acc) begin
            ctrl_q_ready_o = 1'b1;
            local_hs       = 1'b1;
            state_d        = LOCAL_RSP;
            rdata_d        = (is_local(offs) && !ctrl_q_write_i) ? local_rdata : '0;
          end else begin
            periph_req_o[sel] = 1'b1;
            ctrl_q_ready_o    = periph_gnt_i[sel];
            hwpe_hs           = periph_gnt_i[sel];
            if (periph_gnt_i[sel]) begin
              sel_d   = sel;
              state_d = WAIT_HWPE;
            end
          end
        end
      end
      LOCAL_RSP: begin
        ctrl_p_valid_o = 1'b1;
        ctrl_p_data_o  = rdata_q;
        state_d        = IDLE;
      end
      WAIT_HWPE: begin
        ctrl_p_valid_o = periph_r_valid_i[sel_q];
        ctrl_p_data_o  = periph_r_data_i[sel_q*DataWidth +: DataWidth];
        if (periph_r_valid_i[sel_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      clk_en_q  <= '0;
      mux_sel_q <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_en_q  <= clk_en_d;
      mux_sel_q <= mux_sel_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
    end
  end

  assign evt_set = hwpe_evt_i[mux_sel_q*NrCores +: NrCores];

  hwpe_ctrl_evt_sticky #(
    .NrCores(NrCores)
  ) i_evt_sticky (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .set_i (evt_set),
    .clr_i (evt_clr),
    .evt_o (hwpe_evt_o)
  );

  assign clk_en_o  = clk_en_q;
  assign mux_sel_o = mux_sel_q;

  // An HWPE must not answer in the same cycle it grants.
  a_no_rvalid_on_grant: assert property (@(posedge clk_i) disable iff (rst_i)
    !(hwpe_hs && periph_r_valid_i[sel]));

endmodule
